// File: rtl/hold_ctrl.sv
// rtl/hold_ctrl.sv - pipeline hold/flush arbiter with PC redirect and MDU watchdog
// Optional performance counters: define HOLD_CTRL_PERF_EN.
module hold_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TRAP_CYCLES = 2,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              load_use_i,
    input  logic              mdu_start_i,
    input  logic              mdu_done_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic [2:0]        hold_flag_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_redirect_addr_o,
    output logic              mdu_abort_o,
    output logic              busy_o
`ifdef HOLD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam logic [2:0] H_RUN       = 3'b000;
    localparam logic [2:0] H_FLUSH_IF  = 3'b001;
    localparam logic [2:0] H_FLUSH_ID  = 3'b010;
    localparam logic [2:0] H_BUBBLE    = 3'b011;
    localparam logic [2:0] H_FLUSH_ALL = 3'b100;
    localparam logic [2:0] H_FREEZE    = 3'b101;

    localparam int CMAX = (TRAP_CYCLES > MDU_TIMEOUT) ? TRAP_CYCLES : MDU_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TRAP_LOAD = CW'(TRAP_CYCLES - 1);
    localparam logic [CW-1:0] MDU_LAST  = CW'(MDU_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_TRAP_FLUSH,
        S_MDU_WAIT,
        S_MEM_WAIT
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next, cnt_inc;
    logic            take_trap;
    logic [2:0]      hold;
    logic            redir, abort;
    logic [ADDR_W-1:0] redir_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cnt_inc    = (cnt == MDU_LAST) ? cnt : cnt + ONE;
        take_trap  = 1'b0;
        hold       = H_RUN;
        redir      = 1'b0;
        redir_addr = '0;
        abort      = 1'b0;
        case (state)
            S_RUN: begin
                if (trap_i) begin
                    take_trap = 1'b1;
                end else if (jump_flag_i) begin
                    hold       = H_FLUSH_ID;
                    redir      = 1'b1;
                    redir_addr = jump_addr_i;
                end else if (mem_req_i && !mem_ready_i) begin
                    hold       = H_FREEZE;
                    state_next = S_MEM_WAIT;
                end else if (mdu_start_i) begin
                    hold       = H_FREEZE;
                    state_next = S_MDU_WAIT;
                    cnt_next   = '0;
                end else if (load_use_i) begin
                    hold = H_BUBBLE;
                end
            end
            S_TRAP_FLUSH: begin
                // cnt holds the FLUSH_ALL cycles still owed after this one plus one
                hold     = H_FLUSH_ALL;
                cnt_next = cnt - ONE;
                if (cnt == ONE) begin
                    state_next = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_next = S_RUN;
                end else begin
                    hold = H_FREEZE;
                end
            end
            S_MDU_WAIT: begin
                if (trap_i) begin
                    abort     = 1'b1;
                    take_trap = 1'b1;
                end else if (mdu_done_i) begin
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == MDU_LAST) begin
                        abort      = 1'b1;
                        hold       = H_FLUSH_ALL;
                        state_next = S_RUN;
                    end else begin
                        hold = H_FREEZE;
                    end
                end
            end
            default: state_next = S_RUN;
        endcase
        if (take_trap) begin
            hold       = H_FLUSH_ALL;
            redir      = 1'b1;
            redir_addr = trap_addr_i;
            cnt_next   = TRAP_LOAD;
            state_next = (TRAP_CYCLES > 1) ? S_TRAP_FLUSH : S_RUN;
        end
    end

    // Reset masks every output regardless of the registered state.
    assign hold_flag_o        = rst ? H_RUN : hold;
    assign pc_redirect_o      = !rst && redir;
    assign pc_redirect_addr_o = rst ? '0 : redir_addr;
    assign mdu_abort_o        = !rst && abort;
    assign busy_o             = !rst && (state != S_RUN);

`ifdef HOLD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_flag_o == H_BUBBLE || hold_flag_o == H_FREEZE) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (hold_flag_o == H_FLUSH_IF || hold_flag_o == H_FLUSH_ID ||
                hold_flag_o == H_FLUSH_ALL) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hold_ctrl.sv
// tb/tb_hold_ctrl.sv - directed self-checking bench for hold_ctrl
module tb_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        trap_i;
    logic [31:0] trap_addr_i;
    logic        load_use_i;
    logic        mdu_start_i;
    logic        mdu_done_i;
    logic        mem_req_i;
    logic        mem_ready_i;
    logic [2:0]  hold_flag_o;
    logic        pc_redirect_o;
    logic [31:0] pc_redirect_addr_o;
    logic        mdu_abort_o;
    logic        busy_o;
`ifdef HOLD_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hold_ctrl #(
        .ADDR_W(32), .TRAP_CYCLES(2), .MDU_TIMEOUT(8), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .trap_i(trap_i), .trap_addr_i(trap_addr_i),
        .load_use_i(load_use_i),
        .mdu_start_i(mdu_start_i), .mdu_done_i(mdu_done_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .hold_flag_o(hold_flag_o), .pc_redirect_o(pc_redirect_o),
        .pc_redirect_addr_o(pc_redirect_addr_o),
        .mdu_abort_o(mdu_abort_o), .busy_o(busy_o)
`ifdef HOLD_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled mid-low-phase.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        jump_flag_i = 0; trap_i = 0; load_use_i = 0; mdu_start_i = 0;
        mdu_done_i = 0; mem_req_i = 0; mem_ready_i = 0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] h, input logic b, input logic ab);
        #1;
        check({tag, "_hold"}, 32'(hold_flag_o), 32'(h));
        check({tag, "_busy"}, 32'(busy_o), 32'(b));
        check({tag, "_abort"}, 32'(mdu_abort_o), 32'(ab));
    endtask

    initial begin
        rst = 1; idle_inputs();
        jump_addr_i = 32'h8000_0100; trap_addr_i = 32'h8000_0004;
        next_cycle(); next_cycle();
        // Reset masks a live jump request
        jump_flag_i = 1;
        chk_out("rst", 3'b000, 0, 0);
        check("rst_redir", 32'(pc_redirect_o), 32'd0);
        check("rst_addr", pc_redirect_addr_o, 32'd0);
        next_cycle(); rst = 0; idle_inputs();

`ifdef HOLD_CTRL_PERF_EN
        #1;
        check("perf_stall0", stall_cnt_o, 32'd0);
        check("perf_flush0", flush_cnt_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); load_use_i = 1;
        end
        next_cycle(); load_use_i = 0; jump_flag_i = 1;
        next_cycle(); idle_inputs();
        #1;
        check("perf_stall", stall_cnt_o, 32'd3);
        check("perf_flush", flush_cnt_o, 32'd1);
`endif

        // Load-use: one bubble per cycle
        next_cycle(); load_use_i = 1;
        chk_out("lu1", 3'b011, 0, 0);
        next_cycle();
        chk_out("lu2", 3'b011, 0, 0);
        next_cycle(); idle_inputs();
        chk_out("lu_end", 3'b000, 0, 0);

        // Jump
        next_cycle(); jump_flag_i = 1;
        chk_out("jmp", 3'b010, 0, 0);
        check("jmp_redir", 32'(pc_redirect_o), 32'd1);
        check("jmp_addr", pc_redirect_addr_o, 32'h8000_0100);
        next_cycle(); idle_inputs();
        chk_out("jmp_after", 3'b000, 0, 0);
        check("jmp_after_redir", 32'(pc_redirect_o), 32'd0);

        // Trap beats jump; FLUSH_ALL for exactly two cycles
        next_cycle(); trap_i = 1; jump_flag_i = 1;
        chk_out("trap1", 3'b100, 0, 0);
        check("trap_redir", 32'(pc_redirect_o), 32'd1);
        check("trap_addr", pc_redirect_addr_o, 32'h8000_0004);
        next_cycle(); idle_inputs();
        chk_out("trap2", 3'b100, 1, 0);
        check("trap2_redir", 32'(pc_redirect_o), 32'd0);
        next_cycle();
        chk_out("trap_end", 3'b000, 0, 0);

        // Memory wait: three frozen cycles, trap deferred
        next_cycle(); mem_req_i = 1;
        chk_out("mem1", 3'b101, 0, 0);
        next_cycle();
        chk_out("mem2", 3'b101, 1, 0);
        next_cycle(); trap_i = 1;
        chk_out("mem3", 3'b101, 1, 0);
        check("mem3_trap_deferred", 32'(pc_redirect_o), 32'd0);
        next_cycle(); trap_i = 0; mem_ready_i = 1;
        chk_out("mem_ready", 3'b000, 1, 0);
        next_cycle(); idle_inputs();
        chk_out("mem_end", 3'b000, 0, 0);

        // Mem wait and MDU start together: mem first, MDU re-presented on return
        next_cycle(); mem_req_i = 1; mdu_start_i = 1;
        chk_out("mm1", 3'b101, 0, 0);
        next_cycle(); mem_ready_i = 1;
        chk_out("mm_ready", 3'b000, 1, 0);
        next_cycle(); mem_req_i = 0; mem_ready_i = 0;
        chk_out("mm_mdu", 3'b101, 0, 0);
        next_cycle(); mdu_start_i = 0; mdu_done_i = 1;
        chk_out("mm_done", 3'b000, 1, 0);
        next_cycle(); idle_inputs();
        chk_out("mm_end", 3'b000, 0, 0);

        // MDU timeout: 7 frozen cycles then abort with FLUSH_ALL
        next_cycle(); mdu_start_i = 1;
        chk_out("to1", 3'b101, 0, 0);
        next_cycle(); mdu_start_i = 0;
        for (int i = 2; i <= 7; i++) begin
            chk_out($sformatf("to%0d", i), 3'b101, 1, 0);
            next_cycle();
        end
        chk_out("to_abort", 3'b100, 1, 1);
        next_cycle();
        chk_out("to_end", 3'b000, 0, 0);

        // Reset in the second MDU_WAIT cycle
        next_cycle(); mdu_start_i = 1;
        chk_out("rm1", 3'b101, 0, 0);
        next_cycle(); mdu_start_i = 0;
        chk_out("rm2", 3'b101, 1, 0);
        next_cycle(); rst = 1;
        chk_out("rm_rst", 3'b000, 0, 0);
        next_cycle(); rst = 0;
        chk_out("rm_after", 3'b000, 0, 0);

        // Trap during MDU wait aborts it and takes the trap path
        next_cycle(); mdu_start_i = 1;
        chk_out("tm1", 3'b101, 0, 0);
        next_cycle(); mdu_start_i = 0; trap_i = 1;
        chk_out("tm_trap", 3'b100, 1, 1);
        check("tm_addr", pc_redirect_addr_o, 32'h8000_0004);
        next_cycle(); trap_i = 0;
        chk_out("tm_flush", 3'b100, 1, 0);
        next_cycle();
        chk_out("tm_end", 3'b000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
